// File: rtl/side_info_pkg.sv
// Shared widths, granule record type and FSM encoding for the mono
// Layer III side-info packer.
package side_info_pkg;

  localparam int SI_BYTES_MONO = 17;
  localparam int SI_BITS       = SI_BYTES_MONO * 8;
  localparam int GR_BITS       = 59;
  localparam int NUM_GR        = 2;

  localparam int MDB_W   = 9;
  localparam int PRIV_W  = 5;
  localparam int SCFSI_W = 4;
  localparam int P23_W   = 12;
  localparam int BV_W    = 9;
  localparam int GG_W    = 8;
  localparam int SFC_W   = 4;
  localparam int BT_W    = 2;
  localparam int TS_W    = 5;
  localparam int SBG_W   = 3;
  localparam int R0_W    = 4;
  localparam int R1_W    = 3;
  localparam int VAR_W   = 22;
  localparam int CNT_W   = 5;

  // All per-granule fields; the packer picks which ones land in the record.
  typedef struct packed {
    logic [P23_W-1:0]        part2_3_length;
    logic [BV_W-1:0]         big_values;
    logic [GG_W-1:0]         global_gain;
    logic [SFC_W-1:0]        scalefac_compress;
    logic                    window_switching_flag;
    logic [BT_W-1:0]         block_type;
    logic                    mixed_block_flag;
    logic [2:0][TS_W-1:0]    table_select;
    logic [2:0][SBG_W-1:0]   subblock_gain;
    logic [R0_W-1:0]         region0_count;
    logic [R1_W-1:0]         region1_count;
    logic                    preflag;
    logic                    scalefac_scale;
    logic                    count1table_select;
  } granule_t;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

endpackage

// File: rtl/side_info_packer_granule.sv
// Combinational packing of one granule into its 59-bit record, MSB first.
import side_info_pkg::*;

module granule_packer (
  input  granule_t           gr,
  output logic [GR_BITS-1:0] rec
);

  logic [VAR_W-1:0] var_f;

  // 22-bit variant field: block-switched layout vs. region layout.
  always_comb begin
    var_f = '0;
    if (gr.window_switching_flag)
      var_f = {gr.block_type, gr.mixed_block_flag,
               gr.table_select[0], gr.table_select[1],
               gr.subblock_gain[0], gr.subblock_gain[1], gr.subblock_gain[2]};
    else
      var_f = {gr.table_select[0], gr.table_select[1], gr.table_select[2],
               gr.region0_count, gr.region1_count};
  end

  assign rec = {gr.part2_3_length, gr.big_values, gr.global_gain,
                gr.scalefac_compress, gr.window_switching_flag, var_f,
                gr.preflag, gr.scalefac_scale, gr.count1table_select};

endmodule

// File: rtl/side_info_packer.sv
// Packs two granules of mono side info into 17 bytes and streams them
// MSB first over the axiod/axiov/axiir byte bus.
import side_info_pkg::*;

module side_info_packer (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [MDB_W-1:0]            main_data_begin,
  input  logic [PRIV_W-1:0]           private_bits,
  input  logic [SCFSI_W-1:0]          scfsi,
  input  logic [1:0][P23_W-1:0]       part2_3_length,
  input  logic [1:0][BV_W-1:0]        big_values,
  input  logic [1:0][GG_W-1:0]        global_gain,
  input  logic [1:0][SFC_W-1:0]       scalefac_compress,
  input  logic [1:0]                  window_switching_flag,
  input  logic [1:0][BT_W-1:0]        block_type,
  input  logic [1:0]                  mixed_block_flag,
  input  logic [1:0][2:0][TS_W-1:0]   table_select,
  input  logic [1:0][2:0][SBG_W-1:0]  subblock_gain,
  input  logic [1:0][R0_W-1:0]        region0_count,
  input  logic [1:0][R1_W-1:0]        region1_count,
  input  logic [1:0]                  preflag,
  input  logic [1:0]                  scalefac_scale,
  input  logic [1:0]                  count1table_select,
  output logic [7:0]                  axiod,
  output logic                        axiov,
  input  logic                        axiir,
  output logic                        busy,
  output logic                        done
);

  localparam int SI_BYTES = SI_BYTES_MONO;

  granule_t [NUM_GR-1:0]               gr;
  logic     [NUM_GR-1:0][GR_BITS-1:0]  rec;
  logic     [SI_BITS-1:0]              packed_v;
  logic     [SI_BITS-1:0]              shreg;
  logic     [CNT_W-1:0]                cnt;
  state_t                              state;

  for (genvar g = 0; g < NUM_GR; g++) begin : g_gr
    assign gr[g] = '{part2_3_length:        part2_3_length[g],
                     big_values:            big_values[g],
                     global_gain:           global_gain[g],
                     scalefac_compress:     scalefac_compress[g],
                     window_switching_flag: window_switching_flag[g],
                     block_type:            block_type[g],
                     mixed_block_flag:      mixed_block_flag[g],
                     table_select:          table_select[g],
                     subblock_gain:         subblock_gain[g],
                     region0_count:         region0_count[g],
                     region1_count:         region1_count[g],
                     preflag:               preflag[g],
                     scalefac_scale:        scalefac_scale[g],
                     count1table_select:    count1table_select[g]};
    granule_packer u_granule_packer (.gr(gr[g]), .rec(rec[g]));
  end

  // scfsi band 0 is the first bit on the wire.
  assign packed_v = {main_data_begin, private_bits,
                     scfsi[0], scfsi[1], scfsi[2], scfsi[3],
                     rec[0], rec[1]};

  // The top byte of the shift register is the byte on the bus; it drains
  // to zero, so axiod reads 0 whenever nothing is being sent.
  assign axiod = shreg[SI_BITS-1 -: 8];

  // Frame FSM: latch on start, shift one byte per handshake, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      axiov <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg <= packed_v;
            cnt   <= '0;
            axiov <= 1'b1;
            busy  <= 1'b1;
            state <= SEND;
          end
        end
        SEND: begin
          if (axiir) begin
            shreg <= {shreg[SI_BITS-9:0], 8'h00};
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(SI_BYTES - 1)) begin
              axiov <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_side_info_packer.sv
// Bench for side_info_packer: directed layout cases, stalls, start
// filtering, mid-frame reset and randomized frames against a bit-list model.
module tb_side_info_packer;

  logic clk = 1'b0;
  logic rst, start, axiir;
  logic [8:0]             main_data_begin;
  logic [4:0]             private_bits;
  logic [3:0]             scfsi;
  logic [1:0][11:0]       part2_3_length;
  logic [1:0][8:0]        big_values;
  logic [1:0][7:0]        global_gain;
  logic [1:0][3:0]        scalefac_compress;
  logic [1:0]             window_switching_flag;
  logic [1:0][1:0]        block_type;
  logic [1:0]             mixed_block_flag;
  logic [1:0][2:0][4:0]   table_select;
  logic [1:0][2:0][2:0]   subblock_gain;
  logic [1:0][3:0]        region0_count;
  logic [1:0][2:0]        region1_count;
  logic [1:0]             preflag, scalefac_scale, count1table_select;
  logic [7:0]             axiod;
  logic                   axiov, busy, done;

  int checks = 0, failures = 0;

  logic [7:0]  got[$];
  int          done_at, busy_low_at, hold_err, busy_err;
  bit          timed_out;
  logic [31:0] fv[$];
  int          fw[$];

  always #5 clk = ~clk;

  side_info_packer dut (
    .clk(clk), .rst(rst), .start(start),
    .main_data_begin(main_data_begin), .private_bits(private_bits), .scfsi(scfsi),
    .part2_3_length(part2_3_length), .big_values(big_values), .global_gain(global_gain),
    .scalefac_compress(scalefac_compress), .window_switching_flag(window_switching_flag),
    .block_type(block_type), .mixed_block_flag(mixed_block_flag),
    .table_select(table_select), .subblock_gain(subblock_gain),
    .region0_count(region0_count), .region1_count(region1_count),
    .preflag(preflag), .scalefac_scale(scalefac_scale),
    .count1table_select(count1table_select),
    .axiod(axiod), .axiov(axiov), .axiir(axiir), .busy(busy), .done(done)
  );

  task automatic clear_fields();
    main_data_begin = '0; private_bits = '0; scfsi = '0;
    part2_3_length = '0; big_values = '0; global_gain = '0; scalefac_compress = '0;
    window_switching_flag = '0; block_type = '0; mixed_block_flag = '0;
    table_select = '0; subblock_gain = '0; region0_count = '0; region1_count = '0;
    preflag = '0; scalefac_scale = '0; count1table_select = '0;
  endtask

  task automatic rand_fields();
    main_data_begin = 9'($urandom); private_bits = 5'($urandom); scfsi = 4'($urandom);
    for (int g = 0; g < 2; g++) begin
      part2_3_length[g]        = 12'($urandom);
      big_values[g]            = 9'($urandom);
      global_gain[g]           = 8'($urandom);
      scalefac_compress[g]     = 4'($urandom);
      window_switching_flag[g] = 1'($urandom);
      block_type[g]            = 2'($urandom);
      mixed_block_flag[g]      = 1'($urandom);
      for (int i = 0; i < 3; i++) begin
        table_select[g][i]  = 5'($urandom);
        subblock_gain[g][i] = 3'($urandom);
      end
      region0_count[g]      = 4'($urandom);
      region1_count[g]      = 3'($urandom);
      preflag[g]            = 1'($urandom);
      scalefac_scale[g]     = 1'($urandom);
      count1table_select[g] = 1'($urandom);
    end
  endtask

  task automatic add(input logic [31:0] f, input int w);
    fv.push_back(f);
    fw.push_back(w);
  endtask

  // Reference: list the fields in wire order with their widths, then lay
  // the bits down from bit 135 downward.
  task automatic build_model(output logic [135:0] v);
    int p;
    fv.delete(); fw.delete();
    add(main_data_begin, 9); add(private_bits, 5);
    for (int i = 0; i < 4; i++) add(scfsi[i], 1);
    for (int g = 0; g < 2; g++) begin
      add(part2_3_length[g], 12); add(big_values[g], 9); add(global_gain[g], 8);
      add(scalefac_compress[g], 4); add(window_switching_flag[g], 1);
      if (window_switching_flag[g]) begin
        add(block_type[g], 2); add(mixed_block_flag[g], 1);
        add(table_select[g][0], 5); add(table_select[g][1], 5);
        add(subblock_gain[g][0], 3); add(subblock_gain[g][1], 3); add(subblock_gain[g][2], 3);
      end else begin
        add(table_select[g][0], 5); add(table_select[g][1], 5); add(table_select[g][2], 5);
        add(region0_count[g], 4); add(region1_count[g], 3);
      end
      add(preflag[g], 1); add(scalefac_scale[g], 1); add(count1table_select[g], 1);
    end
    v = '0;
    p = 135;
    foreach (fv[j])
      for (int i = fw[j] - 1; i >= 0; i--) begin
        if (p >= 0) v[p] = fv[j][i];
        p--;
      end
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives axiir and records handshaked bytes; cycle 1 is the cycle after start.
  task automatic collect(input int stall_pct, input int stall_byte, input int inject_at,
                         input int max_cyc);
    logic pv_hold;
    logic [7:0] pd;
    int scnt;
    got.delete(); done_at = -1; busy_low_at = -1; hold_err = 0; busy_err = 0;
    timed_out = 1'b1; pv_hold = 1'b0; pd = '0; scnt = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (pv_hold && (axiov !== 1'b1 || axiod !== pd)) hold_err++;
      if (done === 1'b1 && done_at < 0) done_at = c;
      if (done_at >= 0 && busy === 1'b0) begin
        busy_low_at = c;
        timed_out = 1'b0;
        break;
      end
      if (done_at < 0 && busy !== 1'b1) busy_err++;
      start = (c == inject_at);
      if (c == inject_at) begin
        main_data_begin = ~main_data_begin;
        part2_3_length[1] = ~part2_3_length[1];
      end
      if (stall_byte == got.size() && scnt < 3) begin
        axiir = 1'b0;
        scnt++;
      end else begin
        axiir = ($urandom_range(99) >= stall_pct);
      end
      pv_hold = (axiov === 1'b1) && !axiir;
      pd = axiod;
      if (axiov === 1'b1 && axiir) got.push_back(axiod);
      @(negedge clk);
    end
    start = 1'b0;
    axiir = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; axiir = 1'b1;
    clear_fields();
    @(negedge clk); @(negedge clk);
    checks++;
    if ({axiov, busy, done, axiod} !== 11'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000", {axiov, busy, done, axiod});
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (axiov !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_priority axiov=%b busy=%b exp=0 0", axiov, busy);
    end
  endtask

  task automatic test_mdb();
    logic [7:0] e[17];
    clear_fields();
    main_data_begin = 9'h1FF;
    foreach (e[k]) e[k] = 8'h00;
    e[0] = 8'hFF; e[1] = 8'h80;
    kick();
    collect(0, -1, -1, 60);
    checks++;
    if (timed_out || got.size() != 17) begin
      failures++;
      $display("FAIL mdb_count got=%0d exp=17 timeout=%0d", got.size(), timed_out);
    end
    for (int k = 0; k < 17 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== e[k]) begin
        failures++;
        $display("FAIL mdb_byte%0d got=%h exp=%h", k, got[k], e[k]);
      end
    end
    checks++;
    if (done_at != 18 || busy_low_at != 19 || busy_err != 0) begin
      failures++;
      $display("FAIL mdb_timing done_at=%0d busy_low_at=%0d busy_err=%0d exp=18 19 0",
               done_at, busy_low_at, busy_err);
    end
  endtask

  task automatic test_p23();
    logic [7:0] e[17];
    int bad;
    clear_fields();
    part2_3_length[0] = 12'hFFF;
    foreach (e[k]) e[k] = 8'h00;
    e[2] = 8'h3F; e[3] = 8'hFC;
    kick();
    collect(0, -1, -1, 60);
    bad = (got.size() != 17 || timed_out) ? 1 : 0;
    for (int k = 0; k < 17 && k < got.size(); k++)
      if (got[k] !== e[k]) begin
        bad++;
        $display("FAIL p23_byte%0d got=%h exp=%h", k, got[k], e[k]);
      end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL p23_frame bad=%0d count=%0d exp 0 bad and 17 bytes", bad, got.size());
    end
  endtask

  task automatic test_wsf();
    logic [7:0] e[17];
    int bad;
    clear_fields();
    window_switching_flag[0] = 1'b1;
    subblock_gain[0][2] = 3'b111;
    table_select[0][2]  = 5'h1F;
    foreach (e[k]) e[k] = 8'h00;
    e[6] = 8'h10; e[8] = 8'h01; e[9] = 8'hC0;
    kick();
    collect(0, -1, -1, 60);
    bad = (got.size() != 17 || timed_out) ? 1 : 0;
    for (int k = 0; k < 17 && k < got.size(); k++)
      if (got[k] !== e[k]) begin
        bad++;
        $display("FAIL wsf_byte%0d got=%h exp=%h", k, got[k], e[k]);
      end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL wsf_frame bad=%0d count=%0d exp 0 bad and 17 bytes", bad, got.size());
    end
  endtask

  task automatic test_stall();
    clear_fields();
    count1table_select[1] = 1'b1;
    kick();
    collect(0, 5, -1, 80);
    checks++;
    if (timed_out || got.size() != 17) begin
      failures++;
      $display("FAIL stall_count got=%0d exp=17 timeout=%0d", got.size(), timed_out);
    end
    checks++;
    if (hold_err != 0) begin
      failures++;
      $display("FAIL stall_hold got=%0d unstable cycles exp=0", hold_err);
    end
    checks++;
    if (got.size() == 17 && (got[16] !== 8'h01 || got[5] !== 8'h00 || got[0] !== 8'h00)) begin
      failures++;
      $display("FAIL stall_bytes got=%h/%h/%h exp=00/00/01", got[0], got[5], got[16]);
    end
    checks++;
    if (done_at != 21) begin
      failures++;
      $display("FAIL stall_done_at got=%0d exp=21", done_at);
    end
  endtask

  task automatic test_back_to_back();
    logic [135:0] ev;
    int bad;
    rand_fields();
    build_model(ev);
    kick();
    collect(0, -1, 4, 60);
    bad = (got.size() != 17 || timed_out) ? 1 : 0;
    for (int k = 0; k < 17 && k < got.size(); k++)
      if (got[k] !== ev[135-8*k -: 8]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_ignore_start bad=%0d count=%0d exp=0 17", bad, got.size());
    end
    // fields were mutated by the ignored start; the next frame carries them
    build_model(ev);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (axiov !== 1'b1 || axiod !== ev[135:128]) begin
      failures++;
      $display("FAIL b2b_restart axiov=%b axiod=%h exp=1 %h", axiov, axiod, ev[135:128]);
    end
    collect(0, -1, 18, 60);
    bad = (got.size() != 17 || timed_out) ? 1 : 0;
    for (int k = 0; k < 17 && k < got.size(); k++)
      if (got[k] !== ev[135-8*k -: 8]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_second_frame bad=%0d count=%0d exp=0 17", bad, got.size());
    end
    @(negedge clk);
    checks++;
    if (axiov !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_start_in_done axiov=%b busy=%b exp=0 0", axiov, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [135:0] ev;
    int n, pulses, bad;
    rand_fields();
    kick();
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      axiir = 1'b1;
      if (axiov === 1'b1) n++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (n != 8 || axiov !== 1'b0 || busy !== 1'b0 || axiod !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid n=%0d axiov=%b busy=%b axiod=%h exp=8 0 0 00", n, axiov, busy, axiod);
    end
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1 || axiov === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL rst_mid_quiet got=%0d active cycles exp=0", pulses);
    end
    rand_fields();
    build_model(ev);
    kick();
    collect(0, -1, -1, 60);
    bad = (got.size() != 17 || timed_out) ? 1 : 0;
    for (int k = 0; k < 17 && k < got.size(); k++)
      if (got[k] !== ev[135-8*k -: 8]) bad++;
    checks++;
    if (bad != 0 || done_at != 18) begin
      failures++;
      $display("FAIL rst_mid_fresh bad=%0d done_at=%0d exp=0 18", bad, done_at);
    end
  endtask

  task automatic test_random();
    logic [135:0] ev;
    int bad;
    for (int f = 0; f < 16; f++) begin
      rand_fields();
      build_model(ev);
      kick();
      collect(30, -1, -1, 400);
      bad = (got.size() != 17 || timed_out) ? 1 : 0;
      for (int k = 0; k < 17 && k < got.size(); k++)
        if (got[k] !== ev[135-8*k -: 8]) begin
          if (bad == 0)
            $display("FAIL rand%0d_byte%0d got=%h exp=%h", f, k, got[k], ev[135-8*k -: 8]);
          bad++;
        end
      checks++;
      if (bad != 0 || hold_err != 0 || busy_err != 0) begin
        failures++;
        $display("FAIL rand%0d_frame bad=%0d hold_err=%0d busy_err=%0d count=%0d exp=0 0 0 17",
                 f, bad, hold_err, busy_err, got.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_mdb();
    test_p23();
    test_wsf();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/side_info_packer.md
Name: side_info_packer

Overview:
- Encoder-side counterpart of the mono side-info parser. Takes decoded Layer III single-channel side-info fields for two granules.
- Packs them into the 136-bit (17-byte) mono side-info bitstream, MSB first.
- Streams the result one byte per handshake onto the same 8-bit axiod/axiov byte bus the parser consumes.
- Sits between the frame encoder/test source and the frame header/side-info writer, or drives the parser directly in loopback tests.

Parameters:
- SI_BYTES, 17, bytes of mono side info emitted per frame (fixed by format; not for override).
- GR_BITS, 59, bits per granule record (fixed by format).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle request; fields are latched on this cycle when idle
- main_data_begin  input  9  main-data back-pointer
- private_bits  input  5  private bits
- scfsi  input  4  scale-factor selection info; bit i is scfsi band i
- part2_3_length  input  [1:0] x 12  per granule
- big_values  input  [1:0] x 9  per granule
- global_gain  input  [1:0] x 8  per granule
- scalefac_compress  input  [1:0] x 4  per granule
- window_switching_flag  input  [1:0] x 1  per granule
- block_type  input  [1:0] x 2  used only when window_switching_flag=1
- mixed_block_flag  input  [1:0] x 1  used only when window_switching_flag=1
- table_select  input  [1:0][2:0] x 5  index 2 used only when window_switching_flag=0
- subblock_gain  input  [1:0][2:0] x 3  used only when window_switching_flag=1
- region0_count  input  [1:0] x 4  used only when window_switching_flag=0
- region1_count  input  [1:0] x 3  used only when window_switching_flag=0
- preflag, scalefac_scale, count1table_select  input  [1:0] x 1 each  per granule
- axiod  output  8  current side-info byte
- axiov  output  1  axiod valid
- axiir  input  1  downstream ready; a byte transfers when axiov and axiir are both high
- busy  output  1  high from the cycle after an accepted start until the cycle after done
- done  output  1  one-cycle pulse after the final byte transfers

Behaviour:

Bit layout (136-bit vector, bit 135 sent first):
- main_data_begin 135:127, private_bits 126:122, scfsi[0..3] 121:118.
- Granule 0 occupies 117:59; granule 1 occupies 58:0.

Granule layout (offsets from the granule MSB, in order):
- part2_3_length 12, big_values 9, global_gain 8, scalefac_compress 4, window_switching_flag 1.
- Then a 22-bit variant field:
  - window_switching_flag=1: block_type 2, mixed_block_flag 1, table_select[0..1] 5 each, subblock_gain[0..2] 3 each.
  - window_switching_flag=0: table_select[0..2] 5 each, region0_count 4, region1_count 3.
- Then preflag, scalefac_scale, count1table_select.
- Unused inputs are ignored.
- No legality checks: fields are packed verbatim, including block_type=0 with window_switching_flag=1.

Byte mapping:
- Byte k = vector[135-8k : 128-8k], for k = 0..16.

State machine:
- IDLE: axiov=0, busy=0. When start=1, the packed vector is loaded into a 136-bit shift register, the byte counter is cleared, and the state moves to SEND.
- SEND: axiov=1, axiod = shreg[135:128], busy=1.
  - On a handshake, shreg shifts left by 8 and the counter increments.
  - The handshake with counter=16 moves the state to DONE.
  - While axiir=0, axiod and axiov hold stable.
- DONE: done=1, axiov=0, busy=1 for exactly one cycle, then IDLE.
  - start is ignored in DONE.
  - A start in the following IDLE cycle is accepted, so the minimum frame period is 19 cycles when axiir is held high.

Timing:
- Latency: start at cycle N gives byte 0 valid at N+1.
- start while in SEND or DONE is ignored, and the field inputs are not re-sampled.
- Inputs need to be stable only on the start cycle.

Reset:
- rst forces IDLE on the next edge: axiov=0, done=0, busy=0, axiod=0, counter=0, shreg=0.
- This holds mid-transfer; the partial frame is discarded and no done pulse is produced.
- rst has priority over start in the same cycle.

Decomposition:
- Package side_info_pkg holds:
  - field-width localparams;
  - SI_BYTES_MONO=17 and GR_BITS=59;
  - a granule_t packed struct of all per-granule fields;
  - state enum {IDLE, SEND, DONE}.
- Sub-module granule_packer: combinational, takes one granule_t and returns the 59-bit record. Instantiated twice; the top module concatenates the header bits with both records.

Test Plan:
1. main_data_begin=9'h1FF, all else 0, axiir=1 -> bytes FF 80 00 … 00 (17 total); done pulses at start+18, busy drops at start+19.
2. gr0 part2_3_length=12'hFFF, else 0 -> byte2=0x3F, byte3=0xFC, all others 0x00.
3. gr0 window_switching_flag=1, subblock_gain[2]=3'b111, table_select[2]=5'h1F (must be ignored) -> byte6=0x10, byte8=0x01, byte9=0xC0, others 0.
4. gr1 count1table_select=1, axiir low for 3 cycles while byte5 is presented -> axiod/axiov hold byte5 stable; byte16=0x01; exactly 17 handshakes.
5. Second start pulsed during SEND -> ignored, frame unchanged; start the cycle after done -> new frame begins with axiov high on the next cycle.
6. rst asserted after byte 7 transfers -> axiov=0 next cycle, no done pulse; a following start emits a complete fresh 17-byte frame.
